// File: rtl/usb_fs_tx_pkg.sv
// Shared types and line constants for the full-speed USB transmitter.
// Line encodings are {p,n}.
package usb_fs_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_e;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam int         STUFF_LIMIT  = 6;
   localparam int         EOP_SE0_BITS = 2;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_fs_tx_phy_if.sv
// Byte-stream handshake between the packet engine and the USB line transmitter.
interface usb_fs_tx_phy_if;

   logic       pkt_start;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_get;
   logic       tx_busy;

   modport master (
      output pkt_start, tx_data, tx_data_valid,
      input  tx_data_get, tx_busy
   );

   modport slave (
      input  pkt_start, tx_data, tx_data_valid,
      output tx_data_get, tx_busy
   );

endinterface

// File: rtl/usb_fs_nrzi_stuffer.sv
// NRZI encoder with bit stuffing: tracks consecutive ones and the J/K level.
// Each bit_adv starts a new line bit; when stall is high that bit is a stuffed 0.
module usb_fs_nrzi_stuffer
   import usb_fs_tx_pkg::*;
(
   input  logic clk_usb,
   input  logic reset_n,
   input  logic bit_adv,
   input  logic raw_bit,
   input  logic force_se0,
   input  logic force_j,
   output logic stall,
   output logic usb_p,
   output logic usb_n
);

   logic       level_j;
   logic [2:0] ones_cnt;
   logic [1:0] line;

   assign stall = (ones_cnt == 3'(STUFF_LIMIT));

   // Forced symbols park the encoder at J so the next SYNC starts from a known level.
   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         level_j  <= 1'b1;
         ones_cnt <= '0;
      end else if (bit_adv) begin
         if (stall || !raw_bit) begin
            level_j  <= ~level_j;
            ones_cnt <= '0;
         end else begin
            ones_cnt <= ones_cnt + 3'd1;
         end
      end else if (force_se0 || force_j) begin
         level_j  <= 1'b1;
         ones_cnt <= '0;
      end
   end

   always_comb begin
      line = level_j ? LINE_J : LINE_K;
      if (force_se0)
         line = LINE_SE0;
      else if (force_j)
         line = LINE_J;
   end

   assign usb_p = line[1];
   assign usb_n = line[0];

endmodule

// File: rtl/usb_fs_tx_phy.sv
// Full-speed USB line transmitter: SYNC, NRZI/bit-stuffed data bytes, then EOP.
//
//   state      | meaning
//   ST_IDLE    | line J, pads not driven, waiting for pkt_start
//   ST_SYNC    | sending the 8-bit SYNC pattern
//   ST_DATA    | sending the current byte LSB first (plus stuff bits)
//   ST_EOP_SE0 | EOP_SE0_BITS bit periods of SE0
//   ST_EOP_J   | one bit period of J, then release the pads
module usb_fs_tx_phy
   import usb_fs_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk_usb,
   input  logic             reset_n,
   usb_fs_tx_phy_if.slave   tx_if,
   output logic             usb_p_tx,
   output logic             usb_n_tx,
   output logic             usb_tx_en
);

   localparam int            TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          stuffing_q, stuffing_d;
   logic          done_q, done_d;
   logic [1:0]    eop_cnt_q, eop_cnt_d;

   logic strobe;
   logic last_bit;
   logic bit_adv;
   logic raw_bit;
   logic data_get;
   logic stall;

   assign strobe   = (state_q != ST_IDLE) && (timer_q == '0);
   assign last_bit = (bit_idx_q == 3'd7);

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n)
         timer_q <= TIMER_LOAD;
      else if (state_q == ST_IDLE || timer_q == '0)
         timer_q <= TIMER_LOAD;
      else
         timer_q <= timer_q - 1'b1;
   end

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         stuffing_q <= 1'b0;
         done_q     <= 1'b0;
         eop_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         stuffing_q <= stuffing_d;
         done_q     <= done_d;
         eop_cnt_q  <= eop_cnt_d;
      end
   end

   // shreg_q[0] is the bit currently on the line whenever no stuff bit is in flight.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      stuffing_d = stuffing_q;
      done_d     = done_q;
      eop_cnt_d  = eop_cnt_q;
      bit_adv    = 1'b0;
      raw_bit    = shreg_q[0];
      data_get   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_if.pkt_start) begin
               state_d    = ST_SYNC;
               shreg_d    = SYNC_PATTERN;
               bit_idx_d  = '0;
               stuffing_d = 1'b0;
               done_d     = 1'b0;
               bit_adv    = 1'b1;
               raw_bit    = SYNC_PATTERN[0];
            end
         end

         ST_SYNC, ST_DATA: begin
            if (strobe) begin
               if (stuffing_q) begin
                  stuffing_d = 1'b0;
                  if (done_q) begin
                     state_d   = ST_EOP_SE0;
                     eop_cnt_d = 2'(EOP_SE0_BITS - 1);
                  end else begin
                     bit_adv = 1'b1;
                     raw_bit = shreg_q[0];
                  end
               end else begin
                  if (last_bit) begin
                     if (tx_if.tx_data_valid) begin
                        data_get  = 1'b1;
                        shreg_d   = tx_if.tx_data;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                        raw_bit   = tx_if.tx_data[0];
                     end else begin
                        done_d = 1'b1;
                     end
                  end else begin
                     shreg_d   = {1'b0, shreg_q[7:1]};
                     bit_idx_d = bit_idx_q + 3'd1;
                     raw_bit   = shreg_q[1];
                  end

                  // A pending stuff bit goes out even when the stream has ended.
                  if (stall) begin
                     stuffing_d = 1'b1;
                     bit_adv    = 1'b1;
                  end else if (last_bit && !tx_if.tx_data_valid) begin
                     state_d   = ST_EOP_SE0;
                     eop_cnt_d = 2'(EOP_SE0_BITS - 1);
                  end else begin
                     bit_adv = 1'b1;
                  end
               end
            end
         end

         ST_EOP_SE0: begin
            if (strobe) begin
               if (eop_cnt_q == '0)
                  state_d = ST_EOP_J;
               else
                  eop_cnt_d = eop_cnt_q - 2'd1;
            end
         end

         ST_EOP_J: begin
            if (strobe)
               state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   usb_fs_nrzi_stuffer u_nrzi_stuffer (
      .clk_usb   (clk_usb),
      .reset_n   (reset_n),
      .bit_adv   (bit_adv),
      .raw_bit   (raw_bit),
      .force_se0 (state_q == ST_EOP_SE0),
      .force_j   ((state_q == ST_IDLE) || (state_q == ST_EOP_J)),
      .stall     (stall),
      .usb_p     (usb_p_tx),
      .usb_n     (usb_n_tx)
   );

   assign usb_tx_en         = (state_q != ST_IDLE);
   assign tx_if.tx_busy     = (state_q != ST_IDLE);
   assign tx_if.tx_data_get = data_get;

endmodule

// File: tb/tb_usb_fs_tx_phy.sv
// Self-checking bench for usb_fs_tx_phy: line symbols, enable length and fetch timing
// are compared against a flat bitstream model built from each packet's bytes.
module tb_usb_fs_tx_phy;

   localparam int CPB = 4;

   logic clk_usb = 1'b0;
   logic reset_n = 1'b0;
   logic usb_p_tx, usb_n_tx, usb_tx_en;

   usb_fs_tx_phy_if tx_if ();

   usb_fs_tx_phy #(.CLKS_PER_BIT(CPB)) dut (
      .clk_usb   (clk_usb),
      .reset_n   (reset_n),
      .tx_if     (tx_if.slave),
      .usb_p_tx  (usb_p_tx),
      .usb_n_tx  (usb_n_tx),
      .usb_tx_en (usb_tx_en)
   );

   always #5 clk_usb = ~clk_usb;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] pkt[$];
   int         ptr;
   logic [1:0] exp_sym[$];
   int         exp_get[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per line bit: SYNC then bytes LSB first, stuff after six ones, NRZI from J, then SE0 SE0 J.
   task automatic build_model();
      logic       level;
      int         ones;
      int         fpos[$];
      logic [7:0] byt;
      exp_sym.delete();
      exp_get.delete();
      level = 1'b1;
      ones  = 0;
      for (int g = 0; g <= pkt.size(); g++) begin
         byt = (g == 0) ? 8'h80 : pkt[g-1];
         for (int b = 0; b < 8; b++) begin
            if (!byt[b]) begin
               level = ~level;
               ones  = 0;
            end else begin
               ones++;
            end
            exp_sym.push_back(level ? 2'b10 : 2'b01);
            if (b == 7) fpos.push_back(exp_sym.size() - 1);
            if (ones == 6) begin
               level = ~level;
               ones  = 0;
               exp_sym.push_back(level ? 2'b10 : 2'b01);
            end
         end
      end
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b10);
      for (int g = 0; g < pkt.size(); g++)
         exp_get.push_back((fpos[g] + 1) * CPB - 1);
   endtask

   task automatic drive_src();
      if (ptr < pkt.size()) begin
         tx_if.tx_data_valid = 1'b1;
         tx_if.tx_data       = pkt[ptr];
      end else begin
         tx_if.tx_data_valid = 1'b0;
         tx_if.tx_data       = 8'($urandom);
      end
   endtask

   // Called at a negedge; returns at the negedge of the first idle cycle.
   task automatic run_pkt(input int poke_cyc);
      int         cyc;
      int         got_cyc[$];
      logic [1:0] obs[$];
      logic       upd;
      int         n;
      build_model();
      ptr = 0;
      drive_src();
      tx_if.pkt_start = 1'b1;
      @(posedge clk_usb);
      #1 tx_if.pkt_start = 1'b0;
      cyc = 0;
      while (cyc < 2000) begin
         @(negedge clk_usb);
         if (!usb_tx_en) break;
         obs.push_back({usb_p_tx, usb_n_tx});
         check("busy", 32'(tx_if.tx_busy), 32'd1);
         upd = tx_if.tx_data_get;
         if (upd) got_cyc.push_back(cyc);
         cyc++;
         @(posedge clk_usb);
         #1;
         tx_if.pkt_start = (cyc == poke_cyc);
         if (upd) begin
            ptr++;
            drive_src();
         end
      end
      tx_if.pkt_start = 1'b0;
      check("en_len", 32'(obs.size()), 32'(exp_sym.size() * CPB));
      n = (obs.size() < exp_sym.size() * CPB) ? obs.size() : exp_sym.size() * CPB;
      for (int k = 0; k < n; k++)
         check($sformatf("line@%0d", k), 32'(obs[k]), 32'(exp_sym[k / CPB]));
      check("get_count", 32'(got_cyc.size()), 32'(exp_get.size()));
      n = (got_cyc.size() < exp_get.size()) ? got_cyc.size() : exp_get.size();
      for (int i = 0; i < n; i++)
         check($sformatf("get_cyc%0d", i), 32'(got_cyc[i]), 32'(exp_get[i]));
      check("idle_line", 32'({usb_p_tx, usb_n_tx}), 32'(2'b10));
      check("idle_busy", 32'(tx_if.tx_busy), 32'd0);
   endtask

   initial begin
      logic [7:0] rb;
      int         nb;
      tx_if.pkt_start     = 1'b0;
      tx_if.tx_data_valid = 1'b0;
      tx_if.tx_data       = 8'h00;
      repeat (3) @(negedge clk_usb);
      check("rst_en",   32'(usb_tx_en), 32'd0);
      check("rst_line", 32'({usb_p_tx, usb_n_tx}), 32'(2'b10));
      check("rst_busy", 32'(tx_if.tx_busy), 32'd0);
      check("rst_get",  32'(tx_if.tx_data_get), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_usb);

      pkt.delete();
      run_pkt(-1);
      repeat (2) @(negedge clk_usb);
      pkt = '{8'hC3};
      run_pkt(-1);
      pkt = '{8'hFF, 8'hFF};
      run_pkt(50);
      pkt = '{8'h01, 8'h02, 8'h03};
      run_pkt(-1);

      // Reset in the middle of a packet must drop the pads at once.
      pkt = '{8'hA5, 8'h5A};
      ptr = 0;
      drive_src();
      tx_if.pkt_start = 1'b1;
      @(posedge clk_usb);
      #1 tx_if.pkt_start = 1'b0;
      repeat (45) @(negedge clk_usb);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_en",   32'(usb_tx_en), 32'd0);
      check("mid_rst_line", 32'({usb_p_tx, usb_n_tx}), 32'(2'b10));
      check("mid_rst_busy", 32'(tx_if.tx_busy), 32'd0);
      check("mid_rst_get",  32'(tx_if.tx_data_get), 32'd0);
      @(negedge clk_usb);
      reset_n = 1'b1;
      @(negedge clk_usb);
      pkt = '{8'h7E, 8'hFF, 8'h3F};
      run_pkt(-1);

      for (int it = 0; it < 12; it++) begin
         pkt.delete();
         nb = $urandom_range(0, 4);
         for (int i = 0; i < nb; i++) begin
            rb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            pkt.push_back(rb);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk_usb);
         run_pkt(($urandom_range(0, 1) == 1) ? $urandom_range(5, 60) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
